// File: rtl/mips_pkg.sv
// Shared opcode/funct constants, FSM state enum and instruction classifier
// for the multi-cycle MIPS core.
package mips_pkg;

    localparam int NumRegs = 32;
    localparam int RegAw   = 5;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnSll = 6'h00;
    localparam logic [5:0] FnSrl = 6'h02;
    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb, StHalt} state_e;

    typedef enum logic [3:0] {
        InsAlu, InsJr, InsAddi, InsLw, InsSw, InsBeq, InsBne, InsJ, InsJal, InsBad
    } ins_e;

    // Collapse opcode/funct into the handful of behaviours the FSM cares about
    function automatic ins_e decode(input logic [31:0] ir);
        ins_e ins;
        ins = InsBad;
        case (ir[31:26])
            OpRtype: begin
                case (ir[5:0])
                    FnAdd, FnSub, FnAnd, FnOr, FnSlt, FnSll, FnSrl: ins = InsAlu;
                    FnJr:    ins = InsJr;
                    default: ins = InsBad;
                endcase
            end
            OpJ:     ins = InsJ;
            OpJal:   ins = InsJal;
            OpBeq:   ins = InsBeq;
            OpBne:   ins = InsBne;
            OpAddi:  ins = InsAddi;
            OpLw:    ins = InsLw;
            OpSw:    ins = InsSw;
            default: ins = InsBad;
        endcase
        return ins;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [RegAw-1:0] i_ra1,
    input  logic [RegAw-1:0] i_ra2,
    input  logic [RegAw-1:0] i_wa,
    input  logic             i_we,
    input  logic [31:0]      i_wd,
    output logic [31:0]      o_rd1,
    output logic [31:0]      o_rd2
);

    logic [31:0] r_regs [NumRegs];

    // Synchronous clear on reset; writes to register 0 are dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_wa != '0)) begin
            r_regs[i_wa] <= i_wd;
        end
    end

    assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule

// File: rtl/multi_cycle_mips.sv
// Multi-cycle MIPS subset core: IF/ID/EX/MEM/WB sequencing with handshaked
// instruction fetch and data memory, halting on unsupported instructions.
module multi_cycle_mips
    import mips_pkg::*;
#(
    parameter int unsigned DMEM_AW  = 7,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    output logic [31:0]        IR_addr,
    output logic               IR_req,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DMEM_AW-1:0] A,
    output logic [31:0]        Data2Mem,
    input  logic [31:0]        ReadDataMem,
    input  logic               mem_ready,
    output logic               halted
);

    state_e      r_state, w_state_next;
    logic [31:0] r_pc, r_ir, r_rs, r_rt, r_imm, r_alu, r_mdr;
    ins_e        w_ins;
    logic [31:0] w_pc4, w_br_target, w_j_target, w_alu;
    logic [31:0] w_rd1, w_rd2, w_wd;
    logic [4:0]  w_wa;
    logic        w_we, w_fetch;

    assign w_ins       = decode(r_ir);
    assign w_pc4       = r_pc + 32'd4;
    assign w_br_target = w_pc4 + {r_imm[29:0], 2'b00};
    assign w_j_target  = {w_pc4[31:28], r_ir[25:0], 2'b00};

    // ALU result; for loads/stores it is the byte address, for jal the link value
    always_comb begin
        w_alu = '0;
        case (w_ins)
            InsAlu: begin
                case (r_ir[5:0])
                    FnAdd:   w_alu = r_rs + r_rt;
                    FnSub:   w_alu = r_rs - r_rt;
                    FnAnd:   w_alu = r_rs & r_rt;
                    FnOr:    w_alu = r_rs | r_rt;
                    FnSlt:   w_alu = {31'b0, ($signed(r_rs) < $signed(r_rt))};
                    FnSll:   w_alu = r_rt << r_ir[10:6];
                    FnSrl:   w_alu = r_rt >> r_ir[10:6];
                    default: w_alu = '0;
                endcase
            end
            InsAddi, InsLw, InsSw: w_alu = r_rs + r_imm;
            InsJal:                w_alu = w_pc4;
            default:               w_alu = '0;
        endcase
    end

    // Next-state and handshake strobes; strobes idle high outside MEM
    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        CEN          = 1'b1;
        WEN          = 1'b1;
        OEN          = 1'b1;
        unique case (r_state)
            StIf: begin
                w_fetch = 1'b1;
                if (IR_valid) w_state_next = StId;
            end
            StId: w_state_next = StEx;
            StEx: begin
                case (w_ins)
                    InsAlu, InsAddi, InsJal: w_state_next = StWb;
                    InsLw, InsSw:            w_state_next = StMem;
                    InsBad:                  w_state_next = StHalt;
                    default:                 w_state_next = StIf;
                endcase
            end
            StMem: begin
                CEN = 1'b0;
                if (w_ins == InsLw) OEN = 1'b0;
                else                WEN = 1'b0;
                if (mem_ready) w_state_next = (w_ins == InsLw) ? StWb : StIf;
            end
            StWb:    w_state_next = StIf;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StIf;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= StIf;
        else     r_state <= w_state_next;
    end

    // Datapath registers: IR, operand latches, ALU/MDR results and PC updates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_rs  <= '0;
            r_rt  <= '0;
            r_imm <= '0;
            r_alu <= '0;
            r_mdr <= '0;
        end else begin
            case (r_state)
                StIf: if (IR_valid) r_ir <= IR;
                StId: begin
                    r_rs  <= w_rd1;
                    r_rt  <= w_rd2;
                    r_imm <= {{16{r_ir[15]}}, r_ir[15:0]};
                end
                StEx: begin
                    r_alu <= w_alu;
                    case (w_ins)
                        InsBeq:  r_pc <= (r_rs == r_rt) ? w_br_target : w_pc4;
                        InsBne:  r_pc <= (r_rs != r_rt) ? w_br_target : w_pc4;
                        InsJ:    r_pc <= w_j_target;
                        InsJr:   r_pc <= r_rs;
                        default: ;
                    endcase
                end
                StMem: begin
                    if (mem_ready) begin
                        if (w_ins == InsLw) r_mdr <= ReadDataMem;
                        else                r_pc  <= w_pc4;
                    end
                end
                StWb:    r_pc <= (w_ins == InsJal) ? w_j_target : w_pc4;
                default: ;
            endcase
        end
    end

    // Register write-back; reset suppresses any pending write
    assign w_we = (r_state == StWb) && !rst;
    assign w_wa = (w_ins == InsAlu) ? r_ir[15:11] :
                  (w_ins == InsJal) ? 5'd31 : r_ir[20:16];
    assign w_wd = (w_ins == InsLw) ? r_mdr : r_alu;

    mips_regfile u_regfile (
        .i_clk (clk),
        .i_rst (rst),
        .i_ra1 (r_ir[25:21]),
        .i_ra2 (r_ir[20:16]),
        .i_wa  (w_wa),
        .i_we  (w_we),
        .i_wd  (w_wd),
        .o_rd1 (w_rd1),
        .o_rd2 (w_rd2)
    );

    // Fetch request is masked while reset is held so it rises only after release
    assign IR_req   = w_fetch && !rst;
    assign IR_addr  = r_pc;
    assign A        = r_alu[DMEM_AW+1:2];
    assign Data2Mem = r_rt;
    assign halted   = (r_state == StHalt);

endmodule

// File: tb/tb_multi_cycle_mips.sv
// Self-checking bench for multi_cycle_mips: instruction/data memory responders
// driven per instruction, expectations queued and compared on completion.
module tb_multi_cycle_mips;

    localparam int DMEM_AW = 7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        IR_addr;
    logic               IR_req;
    logic [31:0]        IR = '0;
    logic               IR_valid = 1'b0;
    logic               CEN, WEN, OEN;
    logic [DMEM_AW-1:0] A;
    logic [31:0]        Data2Mem;
    logic [31:0]        ReadDataMem = '0;
    logic               mem_ready = 1'b0;
    logic               halted;

    int n_checks = 0;
    int n_fail   = 0;

    multi_cycle_mips #(
        .DMEM_AW  (DMEM_AW),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .IR_addr     (IR_addr),
        .IR_req      (IR_req),
        .IR          (IR),
        .IR_valid    (IR_valid),
        .CEN         (CEN),
        .WEN         (WEN),
        .OEN         (OEN),
        .A           (A),
        .Data2Mem    (Data2Mem),
        .ReadDataMem (ReadDataMem),
        .mem_ready   (mem_ready),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // kind: 0 = no memory access, 1 = store, 2 = load
    typedef struct {
        logic [31:0]        instr;
        logic [31:0]        pc;
        int                 lat;
        int                 ir_wait;
        int                 kind;
        int                 mem_wait;
        logic [DMEM_AW-1:0] a;
        logic [31:0]        d;
        logic [31:0]        rdata;
    } step_t;

    step_t exp_q[$];

    // Observations of one instruction's execution
    bit                 obs_timeout, obs_mem_seen, obs_unstable;
    logic [31:0]        obs_fetch, obs_d;
    logic [DMEM_AW-1:0] obs_a;
    logic               obs_wen, obs_oen;
    int                 obs_cycles, obs_strobe;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    function automatic step_t mk(input logic [31:0] instr, input logic [31:0] pc,
                                 input int lat, input int ir_wait, input int kind,
                                 input int mem_wait, input logic [DMEM_AW-1:0] a,
                                 input logic [31:0] d, input logic [31:0] rdata);
        step_t s;
        s.instr = instr; s.pc = pc; s.lat = lat; s.ir_wait = ir_wait; s.kind = kind;
        s.mem_wait = mem_wait; s.a = a; s.d = d; s.rdata = rdata;
        return s;
    endfunction

    task automatic do_reset();
        rst = 1'b1; IR_valid = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Serve one fetch and any data access; latency counted from the first IF cycle
    task automatic exec_instr(input logic [31:0] instr, input int ir_wait, input int mem_wait,
                              input logic [31:0] rdata);
        int  cyc, irw, memc, guard;
        bit  fetched, done;
        obs_timeout = 0; obs_mem_seen = 0; obs_unstable = 0; obs_strobe = 0;
        obs_a = '0; obs_d = '0; obs_wen = 1'b1; obs_oen = 1'b1;
        guard = 0;
        while (!IR_req && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        obs_fetch = IR_addr;
        cyc = 0; irw = 0; memc = 0; fetched = 0; done = 0;
        while (!done) begin
            if (fetched && (IR_req || halted)) begin
                done = 1;
            end else if (cyc >= 40) begin
                obs_timeout = 1;
                done = 1;
            end else begin
                if (IR_req && !fetched) begin
                    IR       = instr;
                    IR_valid = (irw >= ir_wait);
                    fetched  = IR_valid;
                    irw++;
                end else begin
                    IR_valid = 1'b0;
                end
                if (!CEN) begin
                    if (memc == 0) begin
                        obs_mem_seen = 1; obs_a = A; obs_d = Data2Mem;
                        obs_wen = WEN; obs_oen = OEN;
                    end else if (A !== obs_a || Data2Mem !== obs_d || WEN !== obs_wen) begin
                        obs_unstable = 1;
                    end
                    obs_strobe++;
                    mem_ready   = (memc >= mem_wait);
                    ReadDataMem = mem_ready ? rdata : 32'hDEAD_BEEF;
                    memc++;
                end else begin
                    mem_ready = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        obs_cycles = cyc;
        IR_valid   = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic test_program();
        step_t prog[$];
        step_t e;
        do_reset();
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd1, 16'd5),       32'h00, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),    32'h04, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20),  32'h08, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd3, 16'd8),       32'h0C, 7, 0, 1, 3, 7'd2, 2, 0));
        prog.push_back(mk(enc_i(6'h23, 5'd0, 5'd4, 16'd8),       32'h10, 5, 0, 2, 0, 7'd2, 0, 2));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd4, 16'd12),      32'h14, 4, 0, 1, 0, 7'd3, 2, 0));
        prog.push_back(mk(enc_r(5'd2, 5'd1, 5'd5, 5'd0, 6'h2A),  32'h18, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd5, 16'd0),       32'h1C, 4, 0, 1, 0, 7'd0, 1, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd0, 16'd7),       32'h20, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd0, 16'd4),       32'h24, 4, 0, 1, 0, 7'd1, 0, 0));
        prog.push_back(mk(enc_r(5'd2, 5'd1, 5'd6, 5'd0, 6'h22),  32'h28, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd6, 16'd16),      32'h2C, 4, 0, 1, 0, 7'd4,
                          32'hFFFF_FFF8, 0));
        prog.push_back(mk(enc_r(5'd1, 5'd2, 5'd7, 5'd0, 6'h24),  32'h30, 6, 2, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd7, 16'd20),      32'h34, 4, 0, 1, 0, 7'd5, 5, 0));
        prog.push_back(mk(enc_r(5'd1, 5'd2, 5'd8, 5'd0, 6'h25),  32'h38, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd8, 16'd24),      32'h3C, 4, 0, 1, 0, 7'd6,
                          32'hFFFF_FFFD, 0));
        prog.push_back(mk(enc_r(5'd0, 5'd1, 5'd9, 5'd4, 6'h00),  32'h40, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd9, 16'd28),      32'h44, 4, 0, 1, 0, 7'd7, 32'h50, 0));
        prog.push_back(mk(enc_r(5'd0, 5'd2, 5'd10, 5'd28, 6'h02), 32'h48, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd10, 16'd32),     32'h4C, 4, 0, 1, 0, 7'd8, 32'hF, 0));
        prog.push_back(mk(enc_r(5'd1, 5'd2, 5'd11, 5'd0, 6'h2A), 32'h50, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd11, 16'd36),     32'h54, 4, 0, 1, 0, 7'd9, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd1, 16'h1E),      32'h58, 4, 0, 1, 0, 7'd7, 5, 0));
        for (int i = 0; i < prog.size(); i++) begin
            exp_q.push_back(prog[i]);
            exec_instr(prog[i].instr, prog[i].ir_wait, prog[i].mem_wait, prog[i].rdata);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_timeout || obs_fetch !== e.pc) begin
                n_fail++;
                $display("FAIL prog[%0d] fetch_addr: got %h expected %h (timeout=%0b)",
                         i, obs_fetch, e.pc, obs_timeout);
            end
            n_checks++;
            if (obs_cycles !== e.lat) begin
                n_fail++;
                $display("FAIL prog[%0d] latency: got %0d expected %0d", i, obs_cycles, e.lat);
            end
            n_checks++;
            if (obs_mem_seen !== (e.kind != 0)) begin
                n_fail++;
                $display("FAIL prog[%0d] mem_access: got %0b expected %0b", i, obs_mem_seen,
                         (e.kind != 0));
            end
            if (e.kind != 0) begin
                n_checks++;
                if (obs_a !== e.a || obs_strobe !== e.mem_wait + 1 || obs_unstable) begin
                    n_fail++;
                    $display("FAIL prog[%0d] mem_addr: got A=%h cycles=%0d unstable=%0b expected A=%h cycles=%0d",
                             i, obs_a, obs_strobe, obs_unstable, e.a, e.mem_wait + 1);
                end
                n_checks++;
                if ({obs_wen, obs_oen} !== ((e.kind == 1) ? 2'b01 : 2'b10)) begin
                    n_fail++;
                    $display("FAIL prog[%0d] strobes: got WEN/OEN=%b expected %b", i,
                             {obs_wen, obs_oen}, (e.kind == 1) ? 2'b01 : 2'b10);
                end
                if (e.kind == 1) begin
                    n_checks++;
                    if (obs_d !== e.d) begin
                        n_fail++;
                        $display("FAIL prog[%0d] store_data: got %h expected %h", i, obs_d, e.d);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        step_t e;
        rst = 1'b1; IR_valid = 1'b0; mem_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({IR_req, CEN, WEN, OEN, halted} !== 5'b01110) begin
                n_fail++;
                $display("FAIL reset_outputs: got IR_req,CEN,WEN,OEN,halted=%b expected 01110",
                         {IR_req, CEN, WEN, OEN, halted});
            end
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IR_req !== 1'b1 || IR_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_fetch: got IR_req=%b IR_addr=%h expected 1 00000000",
                     IR_req, IR_addr);
        end
        // $9 held 0x50 before reset; a store of it must now see zero
        exp_q.push_back(mk(enc_i(6'h2B, 5'd0, 5'd9, 16'd0), 32'h0, 4, 0, 1, 0, 7'd0, 0, 0));
        exec_instr(enc_i(6'h2B, 5'd0, 5'd9, 16'd0), 0, 0, 0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_timeout || !obs_mem_seen || obs_d !== e.d || obs_a !== e.a) begin
            n_fail++;
            $display("FAIL reset_regs_cleared: got data=%h A=%h seen=%0b expected data=%h A=%h",
                     obs_d, obs_a, obs_mem_seen, e.d, e.a);
        end
    endtask

    task automatic test_branch();
        step_t prog[$];
        step_t e;
        do_reset();
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd1, 16'd5),     32'h00, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd2, 16'd3),     32'h04, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd3, 16'd1),     32'h08, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd3, 16'd2),     32'h0C, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h04, 5'd1, 5'd1, 16'd2),     32'h10, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_j(6'h02, 26'h4),                 32'h1C, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h05, 5'd1, 5'd1, 16'd2),     32'h10, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_j(6'h02, 26'h8),                 32'h14, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_j(6'h03, 26'h40),                32'h20, 4, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h2B, 5'd0, 5'd31, 16'd0),    32'h100, 4, 0, 1, 0, 7'd0, 32'h24, 0));
        prog.push_back(mk(enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08), 32'h104, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h04, 5'd1, 5'd2, 16'd5),     32'h24, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h05, 5'd1, 5'd2, 16'd3),     32'h28, 3, 0, 0, 0, 7'd0, 0, 0));
        prog.push_back(mk(enc_i(6'h08, 5'd0, 5'd0, 16'd0),     32'h38, 6, 2, 0, 0, 7'd0, 0, 0));
        for (int i = 0; i < prog.size(); i++) begin
            exp_q.push_back(prog[i]);
            exec_instr(prog[i].instr, prog[i].ir_wait, prog[i].mem_wait, prog[i].rdata);
            e = exp_q.pop_front();
            n_checks++;
            if (obs_timeout || obs_fetch !== e.pc) begin
                n_fail++;
                $display("FAIL branch[%0d] fetch_addr: got %h expected %h (timeout=%0b)",
                         i, obs_fetch, e.pc, obs_timeout);
            end
            n_checks++;
            if (obs_cycles !== e.lat) begin
                n_fail++;
                $display("FAIL branch[%0d] latency: got %0d expected %0d", i, obs_cycles, e.lat);
            end
            if (e.kind == 1) begin
                n_checks++;
                if (!obs_mem_seen || obs_d !== e.d || obs_a !== e.a) begin
                    n_fail++;
                    $display("FAIL branch[%0d] store: got data=%h A=%h expected data=%h A=%h",
                             i, obs_d, obs_a, e.d, e.a);
                end
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        exec_instr(32'hFC00_0000, 0, 0, 0);
        n_checks++;
        if (obs_timeout || obs_cycles !== 3) begin
            n_fail++;
            $display("FAIL halt_latency: got %0d expected 3 (timeout=%0b)", obs_cycles, obs_timeout);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({halted, IR_req, CEN, WEN, OEN} !== 5'b10111) begin
                n_fail++;
                $display("FAIL halt_sticky[%0d]: got halted,IR_req,CEN,WEN,OEN=%b expected 10111",
                         k, {halted, IR_req, CEN, WEN, OEN});
            end
            IR       = enc_i(6'h08, 5'd0, 5'd1, 16'd1);
            IR_valid = 1'b1;
            @(negedge clk);
        end
        IR_valid = 1'b0;
        do_reset();
        n_checks++;
        if (halted !== 1'b0 || IR_req !== 1'b1 || IR_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL halt_cleared: got halted=%b IR_req=%b IR_addr=%h expected 0 1 00000000",
                     halted, IR_req, IR_addr);
        end
    endtask

    task automatic test_reset_in_mem();
        int guard;
        do_reset();
        IR       = enc_i(6'h2B, 5'd0, 5'd0, 16'd8);
        IR_valid = 1'b1;
        @(negedge clk);
        IR_valid = 1'b0;
        guard = 0;
        while (CEN && guard < 6) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if ({CEN, WEN, OEN} !== 3'b001 || A !== 7'd2) begin
            n_fail++;
            $display("FAIL rst_mem_enter: got CEN,WEN,OEN=%b A=%h expected 001 02",
                     {CEN, WEN, OEN}, A);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({CEN, WEN, OEN, IR_req, halted} !== 5'b11100) begin
            n_fail++;
            $display("FAIL rst_mem_strobes: got CEN,WEN,OEN,IR_req,halted=%b expected 11100",
                     {CEN, WEN, OEN, IR_req, halted});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (IR_req !== 1'b1 || IR_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mem_pc: got IR_req=%b IR_addr=%h expected 1 00000000",
                     IR_req, IR_addr);
        end
    endtask

    initial begin
        do_reset();
        test_program();
        test_reset();
        test_branch();
        test_halt();
        test_reset_in_mem();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
